// File: rtl/uart_rx_framer.sv
// UART receiver: 2-flop rx synchronizer, free-running baud tick generator and a
// start/data/parity/stop framer with 7/8 data bits, none/even/odd parity and 1/1.5/2 stop bits.
module uart_rx_framer #(
  parameter int OVRSAMPLING = 16,
  parameter int DVSR_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  data_bit,
  input  logic [1:0]            parity,
  input  logic [1:0]            stop_bits,
  output logic [7:0]            dout,
  output logic                  rx_done_tick,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int TW = $clog2(OVRSAMPLING);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVRSAMPLING - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVRSAMPLING / 2 - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic                  rx_meta_q, rx_sync_q;
  logic [DVSR_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic                  tick;
  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shreg_q, shreg_d;
  logic                  bits8_q, bits8_d;
  logic [1:0]            par_mode_q, par_mode_d;
  logic [1:0]            stop_mode_q, stop_mode_d;
  logic                  stop_phase_q, stop_phase_d;
  logic                  par_err_acc_q, par_err_acc_d;
  logic                  stop_err_acc_q, stop_err_acc_d;
  logic                  armed_q, armed_d;
  logic [7:0]            dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;

  logic                  par_en;
  logic [2:0]            last_bit;
  logic                  par_x;
  logic                  finish;
  logic                  fin_ferr;

  assign tick       = (baud_cnt_q == dvsr);
  assign baud_cnt_d = tick ? '0 : baud_cnt_q + DVSR_WIDTH'(1);

  assign par_en   = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
  assign last_bit = bits8_q ? 3'd7 : 3'd6;
  assign par_x    = (^shreg_q) ^ rx_sync_q;

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    bits8_d        = bits8_q;
    par_mode_d     = par_mode_q;
    stop_mode_d    = stop_mode_q;
    stop_phase_d   = stop_phase_q;
    par_err_acc_d  = par_err_acc_q;
    stop_err_acc_d = stop_err_acc_q;
    armed_d        = armed_q;
    dout_d         = dout_q;
    perr_d         = perr_q;
    ferr_d         = ferr_q;
    done_d         = 1'b0;
    finish         = 1'b0;
    fin_ferr       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        // A line still low after a frame must go high before a new start is accepted.
        if (rx_sync_q)    armed_d = 1'b1;
        else if (armed_q) state_d = ST_START;
      end
      ST_START: if (tick) begin
        if (tick_cnt_q == TICK_HALF) begin
          tick_cnt_d = '0;
          if (!rx_sync_q) begin
            state_d        = ST_DATA;
            bit_cnt_d      = '0;
            shreg_d        = '0;
            bits8_d        = data_bit;
            par_mode_d     = parity;
            stop_mode_d    = stop_bits;
            stop_phase_d   = 1'b0;
            par_err_acc_d  = 1'b0;
            stop_err_acc_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      ST_DATA: if (tick) begin
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          shreg_d    = {rx_sync_q, shreg_q[7:1]};
          if (bit_cnt_q == last_bit) begin
            bit_cnt_d = '0;
            state_d   = par_en ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      ST_PARITY: if (tick) begin
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d    = '0;
          par_err_acc_d = (par_mode_q == 2'b10) ? ~par_x : par_x;
          state_d       = ST_STOP;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      ST_STOP: if (tick) begin
        if (!stop_phase_q) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            if ((stop_mode_q == 2'b10) || (stop_mode_q == 2'b01)) begin
              stop_phase_d   = 1'b1;
              stop_err_acc_d = ~rx_sync_q;
            end else begin
              finish   = 1'b1;
              fin_ferr = ~rx_sync_q;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end else if (stop_mode_q == 2'b10) begin
          if (tick_cnt_q == TICK_LAST) begin
            finish   = 1'b1;
            fin_ferr = stop_err_acc_q | ~rx_sync_q;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end else begin
          // One-and-half: the trailing half bit is only waited out, never sampled.
          if (tick_cnt_q == TICK_HALF) begin
            finish   = 1'b1;
            fin_ferr = stop_err_acc_q;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d      = ST_IDLE;
      tick_cnt_d   = '0;
      stop_phase_d = 1'b0;
      armed_d      = 1'b0;
      dout_d       = bits8_q ? shreg_q : {1'b0, shreg_q[7:1]};
      perr_d       = par_err_acc_q;
      ferr_d       = fin_ferr;
      done_d       = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q      <= 1'b1;
      rx_sync_q      <= 1'b1;
      baud_cnt_q     <= '0;
      state_q        <= ST_IDLE;
      tick_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shreg_q        <= '0;
      bits8_q        <= 1'b1;
      par_mode_q     <= 2'b00;
      stop_mode_q    <= 2'b00;
      stop_phase_q   <= 1'b0;
      par_err_acc_q  <= 1'b0;
      stop_err_acc_q <= 1'b0;
      armed_q        <= 1'b1;
      dout_q         <= '0;
      done_q         <= 1'b0;
      perr_q         <= 1'b0;
      ferr_q         <= 1'b0;
    end else begin
      rx_meta_q      <= rx;
      rx_sync_q      <= rx_meta_q;
      baud_cnt_q     <= baud_cnt_d;
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      bits8_q        <= bits8_d;
      par_mode_q     <= par_mode_d;
      stop_mode_q    <= stop_mode_d;
      stop_phase_q   <= stop_phase_d;
      par_err_acc_q  <= par_err_acc_d;
      stop_err_acc_q <= stop_err_acc_d;
      armed_q        <= armed_d;
      dout_q         <= dout_d;
      done_q         <= done_d;
      perr_q         <= perr_d;
      ferr_q         <= ferr_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: a serial line driver pushes expected
// frames to a scoreboard, and a monitor pops and compares them on every rx_done_tick.
module tb_uart_rx_framer;

  localparam int DW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic [DW-1:0] dvsr;
  logic          data_bit;
  logic [1:0]    parity;
  logic [1:0]    stop_bits;
  logic [7:0]    dout;
  logic          rx_done_tick;
  logic          parity_err;
  logic          frame_err;

  typedef struct packed {
    logic [7:0] dout;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   passes     = 0;
  int   done_count = 0;
  int   sent       = 0;

  uart_rx_framer #(.OVRSAMPLING(16), .DVSR_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .dvsr        (dvsr),
    .data_bit    (data_bit),
    .parity      (parity),
    .stop_bits   (stop_bits),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .parity_err  (parity_err),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every completed frame must match the oldest expectation.
  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      exp_t e;
      done_count++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL frame: unexpected rx_done_tick, dout=%02h perr=%0b ferr=%0b, required no frame",
                 dout, parity_err, frame_err);
      end else begin
        e = exp_q.pop_front();
        if ({dout, parity_err, frame_err} !== {e.dout, e.perr, e.ferr})
          $display("FAIL frame: dout=%02h perr=%0b ferr=%0b, required dout=%02h perr=%0b ferr=%0b",
                   dout, parity_err, frame_err, e.dout, e.perr, e.ferr);
        else
          passes++;
      end
    end
  end

  function automatic logic exp_perr(input logic [7:0] d, input int nbits,
                                    input logic [1:0] mode, input logic pbit);
    logic x;
    x = pbit;
    for (int i = 0; i < nbits; i++) x ^= d[i];
    case (mode)
      2'b01:   return x;
      2'b10:   return ~x;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.dout = d;
    e.perr = pe;
    e.ferr = fe;
    exp_q.push_back(e);
    sent++;
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // stop_mode: 0 one, 1 one-and-half, 2 two. Leaves rx at the last stop level.
  task automatic send_frame(input logic [7:0] data, input int nbits, input bit send_par,
                            input logic par_val, input int stop_mode, input logic stop1,
                            input logic stop2, input bit scramble);
    int         bit_clks;
    logic       sv_db;
    logic [1:0] sv_par, sv_stop;
    bit_clks = 16 * (int'(dvsr) + 1);
    sv_db    = data_bit;
    sv_par   = parity;
    sv_stop  = stop_bits;
    hold(1'b0, bit_clks);
    if (scramble) begin
      data_bit  = ~data_bit;
      parity    = (parity == 2'b00) ? 2'b01 : 2'b00;
      stop_bits = (stop_bits == 2'b10) ? 2'b00 : 2'b10;
    end
    for (int i = 0; i < nbits; i++) hold(data[i], bit_clks);
    if (send_par) hold(par_val, bit_clks);
    hold(stop1, bit_clks);
    if (stop_mode == 2)      hold(stop2, bit_clks);
    else if (stop_mode == 1) hold(1'b1, bit_clks / 2);
    data_bit  = sv_db;
    parity    = sv_par;
    stop_bits = sv_stop;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s drain: %0d frames outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      passes++;
    end
    checks++;
    if (done_count !== sent)
      $display("FAIL %s done_count: got %0d, required %0d", name, done_count, sent);
    else
      passes++;
  endtask

  task automatic check_outputs(input string name, input logic [7:0] d, input logic pe, input logic fe);
    checks++;
    if ({dout, parity_err, frame_err, rx_done_tick} !== {d, pe, fe, 1'b0})
      $display("FAIL %s: dout=%02h perr=%0b ferr=%0b done=%0b, required dout=%02h perr=%0b ferr=%0b done=0",
               name, dout, parity_err, frame_err, rx_done_tick, d, pe, fe);
    else
      passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_outputs("reset_in", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs("reset_out", 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_8n1();
    dvsr = '0; data_bit = 1'b1; parity = 2'b00; stop_bits = 2'b00;
    push_exp(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 32);
    wait_drain("8n1_a5");
  endtask

  task automatic test_7e1_parity();
    data_bit = 1'b0; parity = 2'b01; stop_bits = 2'b00;
    push_exp(8'h41, 1'b1, 1'b0);
    send_frame(8'h41, 7, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 32);
    wait_drain("7e1_41");
  endtask

  task automatic test_frame_err();
    data_bit = 1'b1; parity = 2'b00; stop_bits = 2'b00;
    push_exp(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    // Line held low well past a full frame time must not retrigger.
    hold(1'b0, 16 * 12);
    hold(1'b1, 64);
    wait_drain("8n1_3c_stop0");
  endtask

  task automatic test_glitch();
    hold(1'b0, 4);
    hold(1'b1, 60);
    checks++;
    if (done_count !== sent)
      $display("FAIL glitch done_count: got %0d, required %0d", done_count, sent);
    else
      passes++;
    check_outputs("glitch_hold", 8'h3C, 1'b0, 1'b1);
  endtask

  task automatic test_8o2();
    data_bit = 1'b1; parity = 2'b10; stop_bits = 2'b10;
    push_exp(8'hFF, 1'b0, 1'b1);
    send_frame(8'hFF, 8, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 32);
    wait_drain("8o2_stop2_low");
    push_exp(8'hFF, 1'b0, 1'b0);
    send_frame(8'hFF, 8, 1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 32);
    wait_drain("8o2_ok");
  endtask

  task automatic test_reset_mid();
    data_bit = 1'b1; parity = 2'b00; stop_bits = 2'b00;
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 16);
    hold(1'b1, 8);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs("reset_mid", 8'h00, 1'b0, 1'b0);
    hold(1'b1, 200);
    checks++;
    if (done_count !== sent)
      $display("FAIL reset_mid done_count: got %0d, required %0d", done_count, sent);
    else
      passes++;
    push_exp(8'h12, 1'b0, 1'b0);
    send_frame(8'h12, 8, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 32);
    wait_drain("after_reset_12");
  endtask

  task automatic test_config_latch();
    data_bit = 1'b1; parity = 2'b00; stop_bits = 2'b00;
    push_exp(8'h96, 1'b0, 1'b0);
    send_frame(8'h96, 8, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 32);
    wait_drain("latch_96");
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       p;
    // 8E1.5 at a slower baud, frames sent with no idle gap between them.
    dvsr = DW'(3); data_bit = 1'b1; parity = 2'b01; stop_bits = 2'b01;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      push_exp(d, exp_perr(d, 8, 2'b01, p), 1'b0);
      send_frame(d, 8, 1'b1, p, 1, 1'b1, 1'b1, 1'b0);
    end
    hold(1'b1, 128);
    wait_drain("b2b_8e15");
    // 7O2: bit 7 of dout must read 0 whatever follows on the line.
    dvsr = DW'(1); data_bit = 1'b0; parity = 2'b10; stop_bits = 2'b10;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      push_exp({1'b0, d[6:0]}, exp_perr(d, 7, 2'b10, p), 1'b0);
      send_frame(d, 7, 1'b1, p, 2, 1'b1, 1'b1, 1'b0);
    end
    hold(1'b1, 64);
    wait_drain("b2b_7o2");
  endtask

  initial begin
    reset     = 1'b1;
    rx        = 1'b1;
    dvsr      = '0;
    data_bit  = 1'b1;
    parity    = 2'b00;
    stop_bits = 2'b00;
    @(negedge clk);
    test_reset();
    test_8n1();
    test_7e1_parity();
    test_frame_err();
    test_glitch();
    test_8o2();
    test_reset_mid();
    test_config_latch();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
